// File: rtl/saleterminal_pkg.sv
// Shared constants, button indices and controller state type for the sale terminal.
// Cursor helper functions keep the wrap arithmetic out of the controller body.
package saleterminal_pkg;

    localparam int GRID_COLS    = 4;
    localparam int GRID_ROWS    = 3;
    localparam int NUM_PRODUCTS = GRID_COLS * GRID_ROWS;
    localparam int BASKET_DEPTH = 12;

    localparam int NUM_BTNS       = 5;
    localparam int BTN_IDX_UP     = 0;
    localparam int BTN_IDX_DOWN   = 1;
    localparam int BTN_IDX_LEFT   = 2;
    localparam int BTN_IDX_RIGHT  = 3;
    localparam int BTN_IDX_SELECT = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        REMOVE = 1'b1
    } ctl_state_t;

    typedef logic [3:0] idx_t;

    // Row and column wrap independently, so a step never leaves its row/column.
    function automatic idx_t grid_move(input idx_t c, input int drow, input int dcol);
        int row;
        int col;
        row = (int'(c) / GRID_COLS + drow + GRID_ROWS) % GRID_ROWS;
        col = (int'(c) % GRID_COLS + dcol + GRID_COLS) % GRID_COLS;
        return idx_t'(row * GRID_COLS + col);
    endfunction

    function automatic idx_t ring_step(input idx_t v, input idx_t n, input logic dec);
        if (dec)
            return (v == 4'd0) ? n - 4'd1 : v - 4'd1;
        return (v == n - 4'd1) ? 4'd0 : v + 4'd1;
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Raw button -> 2-FF sync -> level debounce -> one-cycle rising-edge pulse.
// With HOVER_AUTOREPEAT_EN defined, a held button also emits delayed periodic repeat pulses.
module btn_debouncer #(
`ifdef HOVER_AUTOREPEAT_EN
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit REPEAT_EN       = 1'b1,
`endif
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic          r_stable_d;
    logic          r_pulse;
    logic [DW-1:0] r_db_cnt;
    logic          w_edge;

    assign w_edge  = r_stable & ~r_stable_d;
    assign o_pulse = r_pulse;

    // The synchronised level must disagree with the accepted level for DEBOUNCE_CYCLES in a row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync     <= 2'b00;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sync     <= {r_sync[0], i_btn};
            r_stable_d <= r_stable;
            if (r_sync[1] == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_stable <= r_sync[1];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

`ifdef HOVER_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] r_rpt_cnt;
    logic          r_rpt_armed;
    logic          w_rpt;

    assign w_rpt = REPEAT_EN && r_stable &&
                   (r_rpt_armed ? (r_rpt_cnt == RW'(REPEAT_PERIOD - 1))
                                : (r_rpt_cnt == RW'(REPEAT_DELAY - 1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rpt_cnt   <= '0;
            r_rpt_armed <= 1'b0;
        end else if (!r_stable || !REPEAT_EN) begin
            r_rpt_cnt   <= '0;
            r_rpt_armed <= 1'b0;
        end else if (w_rpt) begin
            r_rpt_cnt   <= '0;
            r_rpt_armed <= 1'b1;
        end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_pulse <= 1'b0;
        else          r_pulse <= w_edge | w_rpt;
    end
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_pulse <= 1'b0;
        else          r_pulse <= w_edge;
    end
`endif

endmodule

// File: rtl/hover_basket_controller.sv
// Button-driven browse/basket cursor sequencer with a shifting remove FSM and frame-synchronous publish.
// Define HOVER_AUTOREPEAT_EN to enable auto-repeat on the direction buttons.
module hover_basket_controller
    import saleterminal_pkg::*;
#(
`ifdef HOVER_AUTOREPEAT_EN
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000,
`endif
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    BTN_UP,
    input  logic                    BTN_DOWN,
    input  logic                    BTN_LEFT,
    input  logic                    BTN_RIGHT,
    input  logic                    BTN_SELECT,
    input  logic                    SW2,
    input  logic                    FRAME_TICK,
    input  logic [3:0]              BasketRdIdx,
    output logic [3:0]              BasketRdID,
    output logic [NUM_PRODUCTS-1:0] HighlightedProductList,
    output logic [3:0]              BasketProductNum,
    output logic                    BasketFull,
    output logic                    Busy
);

    localparam logic [3:0] DEPTH_C = 4'(BASKET_DEPTH);

    logic [NUM_BTNS-1:0]     w_btn_raw;
    logic [NUM_BTNS-1:0]     w_pulse;
    logic [1:0]              r_sw_sync;
    logic                    r_sw_d;
    logic                    w_mode;
    logic                    w_sw_edge;
    logic                    w_busy;
    logic                    w_cmd_sel, w_cmd_up, w_cmd_down, w_cmd_left, w_cmd_right;
    logic                    w_rm_start, w_rm_shift, w_rm_last;
    ctl_state_t              r_state, w_state_nxt;
    idx_t                    r_cur, r_bcur, r_count, r_rm_idx;
    idx_t                    w_cnt_dec;
    idx_t                    r_bsk [BASKET_DEPTH];
    logic [NUM_PRODUCTS-1:0] w_hl;
    logic [NUM_PRODUCTS-1:0] r_pub_hl;
    idx_t                    r_pub_num;
    logic                    r_full;

    always_comb begin
        w_btn_raw                 = '0;
        w_btn_raw[BTN_IDX_UP]     = BTN_UP;
        w_btn_raw[BTN_IDX_DOWN]   = BTN_DOWN;
        w_btn_raw[BTN_IDX_LEFT]   = BTN_LEFT;
        w_btn_raw[BTN_IDX_RIGHT]  = BTN_RIGHT;
        w_btn_raw[BTN_IDX_SELECT] = BTN_SELECT;
    end

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
        btn_debouncer #(
`ifdef HOVER_AUTOREPEAT_EN
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (gi != BTN_IDX_SELECT),
`endif
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .i_clk  (CLK),
            .i_rst_n(RST_N),
            .i_btn  (w_btn_raw[gi]),
            .o_pulse(w_pulse[gi])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sw_sync <= 2'b00;
            r_sw_d    <= 1'b0;
        end else begin
            r_sw_sync <= {r_sw_sync[0], SW2};
            r_sw_d    <= r_sw_sync[1];
        end
    end

    assign w_mode    = r_sw_sync[1];
    assign w_sw_edge = r_sw_sync[1] ^ r_sw_d;

    // Exactly one command survives per cycle, and none while a remove is in flight.
    assign w_cmd_sel   = ~w_busy & w_pulse[BTN_IDX_SELECT];
    assign w_cmd_up    = ~w_busy & ~w_pulse[BTN_IDX_SELECT] & w_pulse[BTN_IDX_UP];
    assign w_cmd_down  = ~w_busy & ~w_pulse[BTN_IDX_SELECT] & ~w_pulse[BTN_IDX_UP]
                       & w_pulse[BTN_IDX_DOWN];
    assign w_cmd_left  = ~w_busy & ~w_pulse[BTN_IDX_SELECT] & ~w_pulse[BTN_IDX_UP]
                       & ~w_pulse[BTN_IDX_DOWN] & w_pulse[BTN_IDX_LEFT];
    assign w_cmd_right = ~w_busy & ~w_pulse[BTN_IDX_SELECT] & ~w_pulse[BTN_IDX_UP]
                       & ~w_pulse[BTN_IDX_DOWN] & ~w_pulse[BTN_IDX_LEFT] & w_pulse[BTN_IDX_RIGHT];

    assign w_rm_start = w_cmd_sel & w_mode & (r_count != 4'd0);
    assign w_rm_shift = ({1'b0, r_rm_idx} + 5'd1) <  {1'b0, r_count};
    assign w_rm_last  = ({1'b0, r_rm_idx} + 5'd2) >= {1'b0, r_count};
    assign w_cnt_dec  = r_count - 4'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_rm_start) w_state_nxt = REMOVE;
            REMOVE:  if (w_rm_last)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == REMOVE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cur    <= '0;
            r_bcur   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_rm_idx <= '0;
            for (int i = 0; i < BASKET_DEPTH; i++) r_bsk[i] <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (!w_mode) begin
                    if (w_cmd_sel) begin
                        if (r_count < DEPTH_C) begin
                            r_bsk[r_count] <= r_cur;
                            r_count        <= r_count + 4'd1;
                        end else begin
                            r_full <= 1'b1;
                        end
                    end
                    else if (w_cmd_up)    r_cur <= grid_move(r_cur, -1,  0);
                    else if (w_cmd_down)  r_cur <= grid_move(r_cur,  1,  0);
                    else if (w_cmd_left)  r_cur <= grid_move(r_cur,  0, -1);
                    else if (w_cmd_right) r_cur <= grid_move(r_cur,  0,  1);
                end else if (r_count != 4'd0) begin
                    if (w_cmd_sel)       r_rm_idx <= r_bcur;
                    else if (w_cmd_up)   r_bcur   <= ring_step(r_bcur, r_count, 1'b1);
                    else if (w_cmd_down) r_bcur   <= ring_step(r_bcur, r_count, 1'b0);
                end
            end else begin
                // One entry closes the gap per cycle; the last cycle also commits the new count.
                if (w_rm_shift) r_bsk[r_rm_idx] <= r_bsk[r_rm_idx + 4'd1];
                r_rm_idx <= r_rm_idx + 4'd1;
                if (w_rm_last) begin
                    r_count <= w_cnt_dec;
                    r_full  <= 1'b0;
                    if (w_cnt_dec == 4'd0)       r_bcur <= '0;
                    else if (r_bcur == w_cnt_dec) r_bcur <= w_cnt_dec - 4'd1;
                end
            end
            if (w_sw_edge) r_bcur <= '0;
        end
    end

    always_comb begin
        w_hl = '0;
        if (!w_mode)               w_hl = NUM_PRODUCTS'(1) << r_cur;
        else if (r_count != 4'd0)  w_hl = NUM_PRODUCTS'(1) << r_bcur;
    end

    // Publishing only in IDLE keeps a half-shifted basket off the screen.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pub_hl  <= NUM_PRODUCTS'(1);
            r_pub_num <= '0;
        end else if (FRAME_TICK && (r_state == IDLE)) begin
            r_pub_hl  <= w_hl;
            r_pub_num <= r_count;
        end
    end

    always_comb begin
        BasketRdID = 4'd0;
        if (BasketRdIdx < r_count) BasketRdID = r_bsk[BasketRdIdx];
    end

    assign HighlightedProductList = r_pub_hl;
    assign BasketProductNum       = r_pub_num;
    assign BasketFull             = r_full;
    assign Busy                   = w_busy;

endmodule

// File: tb/tb_hover_basket_controller.sv
// Scoreboard bench for hover_basket_controller: directed scenarios then randomized button traffic.
module tb_hover_basket_controller;

    localparam int D      = 4;
    localparam int B_UP   = 0;
    localparam int B_DOWN = 1;
    localparam int B_LEFT = 2;
    localparam int B_RGT  = 3;
    localparam int B_SEL  = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        BTN_UP = 1'b0, BTN_DOWN = 1'b0, BTN_LEFT = 1'b0, BTN_RIGHT = 1'b0, BTN_SELECT = 1'b0;
    logic        SW2 = 1'b0;
    logic        FRAME_TICK = 1'b0;
    logic [3:0]  BasketRdIdx = 4'd0;
    logic [3:0]  BasketRdID;
    logic [11:0] HighlightedProductList;
    logic [3:0]  BasketProductNum;
    logic        BasketFull;
    logic        Busy;

    hover_basket_controller #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK                   (CLK),
        .RST_N                 (RST_N),
        .BTN_UP                (BTN_UP),
        .BTN_DOWN              (BTN_DOWN),
        .BTN_LEFT              (BTN_LEFT),
        .BTN_RIGHT             (BTN_RIGHT),
        .BTN_SELECT            (BTN_SELECT),
        .SW2                   (SW2),
        .FRAME_TICK            (FRAME_TICK),
        .BasketRdIdx           (BasketRdIdx),
        .BasketRdID            (BasketRdID),
        .HighlightedProductList(HighlightedProductList),
        .BasketProductNum      (BasketProductNum),
        .BasketFull            (BasketFull),
        .Busy                  (Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [11:0] hl;
        int          num;
        bit          full;
    } pub_t;

    pub_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: product grid as (row, col), basket as a plain queue.
    int          m_c = 0;
    int          m_b = 0;
    int          m_bsk[$];
    bit          m_mode = 1'b0;
    bit          m_full = 1'b0;
    logic [11:0] m_pub_hl = 12'h001;
    int          m_pub_num = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [11:0] model_hl();
        if (!m_mode) return 12'(1) << m_c;
        if (m_bsk.size() > 0) return 12'(1) << m_b;
        return 12'h000;
    endfunction

    function automatic void apply(input int btn);
        int n = m_bsk.size();
        int row = m_c / 4;
        int col = m_c % 4;
        if (!m_mode) begin
            case (btn)
                B_SEL:  if (n < 12) m_bsk.push_back(m_c); else m_full = 1'b1;
                B_UP:   m_c = ((row + 2) % 3) * 4 + col;
                B_DOWN: m_c = ((row + 1) % 3) * 4 + col;
                B_LEFT: m_c = row * 4 + (col + 3) % 4;
                B_RGT:  m_c = row * 4 + (col + 1) % 4;
                default: ;
            endcase
        end else if (n > 0) begin
            case (btn)
                B_SEL: begin
                    m_bsk.delete(m_b);
                    m_full = 1'b0;
                    n = n - 1;
                    if (n == 0)        m_b = 0;
                    else if (m_b == n) m_b = n - 1;
                end
                B_UP:   m_b = (m_b + n - 1) % n;
                B_DOWN: m_b = (m_b + 1) % n;
                default: ;
            endcase
        end
    endfunction

    function automatic int prio(input logic [4:0] mask);
        if (mask[B_SEL]) return B_SEL;
        for (int i = 0; i < 4; i++) if (mask[i]) return i;
        return -1;
    endfunction

    task automatic drive(input logic [4:0] mask);
        BTN_UP     = mask[B_UP];
        BTN_DOWN   = mask[B_DOWN];
        BTN_LEFT   = mask[B_LEFT];
        BTN_RIGHT  = mask[B_RGT];
        BTN_SELECT = mask[B_SEL];
    endtask

    task automatic press_mask(input logic [4:0] mask);
        @(negedge CLK);
        drive(mask);
        repeat (D + 8) @(negedge CLK);
        drive(5'b0);
        repeat (D + 16) @(negedge CLK);
        if (prio(mask) >= 0) apply(prio(mask));
    endtask

    task automatic press(input int btn);
        logic [4:0] m;
        m = 5'b0;
        m[btn] = 1'b1;
        press_mask(m);
    endtask

    task automatic set_mode(input bit md);
        @(negedge CLK);
        SW2 = md;
        repeat (6) @(negedge CLK);
        if (md != m_mode) begin
            m_mode = md;
            m_b    = 0;
        end
    endtask

    task automatic push_expect();
        pub_t e;
        e.hl   = m_pub_hl;
        e.num  = m_pub_num;
        e.full = m_full;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge CLK);
        FRAME_TICK = 1'b1;
        m_pub_hl  = model_hl();
        m_pub_num = m_bsk.size();
        push_expect();
        @(negedge CLK);
        FRAME_TICK = 1'b0;
    endtask

    task automatic rd_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            BasketRdIdx = 4'(i);
            #1;
            check($sformatf("%s_rd%0d", tag, i), int'(BasketRdID), (i < m_bsk.size()) ? m_bsk[i] : 0);
        end
    endtask

    task automatic wait_busy(input string tag);
        int k = 0;
        while (Busy !== 1'b1 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        check(tag, int'(Busy), 1);
    endtask

    // Monitor: each sampled FRAME_TICK is a published-output event.
    initial begin
        pub_t e;
        forever begin
            @(posedge CLK);
            if (FRAME_TICK === 1'b1 && RST_N === 1'b1) begin
                @(negedge CLK);
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: got output event, expected none queued");
                end else begin
                    e = sb_q.pop_front();
                    check("pub_hl",   int'(HighlightedProductList), int'(e.hl));
                    check("pub_num",  int'(BasketProductNum), e.num);
                    check("pub_full", int'(BasketFull), int'(e.full));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_hl",   int'(HighlightedProductList), 12'h001);
        check("rst_num",  int'(BasketProductNum), 0);
        check("rst_full", int'(BasketFull), 0);
        check("rst_busy", int'(Busy), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        tick();

        for (int i = 0; i < 4; i++) press(B_RGT);
        tick();
        press(B_UP);
        tick();

        press(B_DOWN);
        press(B_DOWN);
        press(B_RGT);
        for (int i = 0; i < 12; i++) press(B_SEL);
        tick();
        press(B_SEL);
        tick();
        check("full_sticky", int'(BasketFull), 1);

        // Reset in the middle of a long remove.
        set_mode(1'b1);
        @(negedge CLK);
        BTN_SELECT = 1'b1;
        wait_busy("rm_long_busy");
        repeat (3) @(negedge CLK);
        check("rm_long_still_busy", int'(Busy), 1);
        #1 RST_N = 1'b0;
        BasketRdIdx = 4'd0;
        #1;
        check("arst_hl",   int'(HighlightedProductList), 12'h001);
        check("arst_num",  int'(BasketProductNum), 0);
        check("arst_full", int'(BasketFull), 0);
        check("arst_busy", int'(Busy), 0);
        BTN_SELECT = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        m_c = 0; m_b = 0; m_bsk.delete(); m_full = 1'b0; m_pub_hl = 12'h001; m_pub_num = 0;
        repeat (10) @(negedge CLK);
        #1;
        check("arst_rd0", int'(BasketRdID), 0);
        tick();

        set_mode(1'b0);
        press(B_RGT); press(B_RGT); press(B_SEL);
        press(B_DOWN); press(B_RGT); press(B_SEL);
        press(B_DOWN); press(B_LEFT); press(B_LEFT); press(B_SEL);
        set_mode(1'b1);
        tick();

        // Remove entry 0 of {2,7,9}; a frame tick lands while the shift is running.
        @(negedge CLK);
        BTN_SELECT = 1'b1;
        wait_busy("rm_busy");
        FRAME_TICK = 1'b1;
        push_expect();
        n = 0;
        do begin
            n++;
            @(negedge CLK);
            FRAME_TICK = 1'b0;
        end while (Busy === 1'b1 && n < 50);
        check("rm_busy_cycles", n, 2);
        BTN_SELECT = 1'b0;
        repeat (D + 16) @(negedge CLK);
        apply(B_SEL);
        rd_sweep("rm3");
        tick();

        set_mode(1'b0);
        press_mask(5'b10001);
        tick();

        for (int it = 0; it < 80; it++) begin
            int r = $urandom_range(0, 9);
            if (r < 6)       press($urandom_range(0, 4));
            else if (r < 7)  set_mode(~m_mode);
            else if (r < 9)  press_mask(5'($urandom_range(1, 31)));
            else             rd_sweep("rnd");
            tick();
        end
        rd_sweep("final");

        repeat (4) @(negedge CLK);
        check("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
